// File: rtl/lbist_pkg.sv
// lbist_pkg: shared FSM state type, LFSR tap masks and phase-shifter offsets for the LBIST pattern generator
package lbist_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // x^24+x^7+x^2+x+1 and x^23+x^5+1
    localparam logic [23:0] TAPS24 = 24'h000086;
    localparam logic [23:0] TAPS23 = 24'h000020;

    localparam int PS_OFF_A = 7;
    localparam int PS_OFF_B = 13;

    function automatic logic [23:0] tap_mask(input int n);
        return (n == 23) ? TAPS23 : TAPS24;
    endfunction

endpackage

// File: rtl/lbist_lfsr_core.sv
// lbist_lfsr_core: Galois LFSR register with zero-seed substitution so it can never lock up
module lbist_lfsr_core
    import lbist_pkg::*;
#(
    parameter int N    = 24,
    parameter int SEED = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] r
);

    localparam logic [23:0]  TAP_FULL = tap_mask(N);
    localparam logic [N-1:0] TAPS     = TAP_FULL[N-1:0];
    localparam logic [N-1:0] SEED_R   = N'(SEED);
    localparam logic [N-1:0] SEED_V   = (SEED_R == '0) ? N'(1) : SEED_R;

    if (N != 23 && N != 24) begin : g_bad_n
        $error("lbist_lfsr_core: N must be 23 or 24");
    end

    always_ff @(posedge clk)
        if (rst)
            r <= SEED_V;
        else if (load)
            r <= (load_val == '0) ? N'(1) : load_val;
        else if (step)
            r <= {r[N-2:0], r[N-1]} ^ (TAPS & {N{r[N-1]}});

endmodule

// File: rtl/lbist_prpg.sv
// lbist_prpg: LBIST pseudo-random pattern generator with valid/ready handoff and run control.
// Define LBIST_PRPG_PHASE_SHIFT_EN to XOR each pattern bit with two rotated LFSR taps.
module lbist_prpg
    import lbist_pkg::*;
#(
    parameter int N    = 24,
    parameter int SEED = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [N-1:0] seed_in,
    input  logic         start,
    input  logic         abort,
    input  logic [15:0]  n_patterns,
    output logic [N-1:0] pattern,
    output logic         pattern_valid,
    input  logic         pattern_ready,
    output logic         misr_en,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pat_idx
);

    state_t       state;
    logic [15:0]  n_lat;
    logic [N-1:0] r;

    assign pattern_valid = (state == S_RUN);
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);
    assign misr_en       = pattern_valid & pattern_ready;

    lbist_lfsr_core #(.N(N), .SEED(SEED)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == S_IDLE) && seed_load),
        .step     (misr_en && !abort),
        .load_val (seed_in),
        .r        (r)
    );

`ifdef LBIST_PRPG_PHASE_SHIFT_EN
    for (genvar i = 0; i < N; i++) begin : g_ps
        assign pattern[i] = r[i] ^ r[(i + PS_OFF_A) % N] ^ r[(i + PS_OFF_B) % N];
    end
`else
    assign pattern = r;
`endif

    // pat_idx counts completed handshakes, so it ends a run at n_patterns
    always_ff @(posedge clk)
        if (rst) begin
            state   <= S_IDLE;
            pat_idx <= '0;
            n_lat   <= '0;
        end else begin
            unique case (state)
                S_IDLE:
                    if (start) begin
                        n_lat   <= n_patterns;
                        pat_idx <= '0;
                        state   <= (n_patterns != 16'd0) ? S_RUN : S_DONE;
                    end
                S_RUN:
                    if (abort)
                        state <= S_IDLE;
                    else if (pattern_ready) begin
                        pat_idx <= pat_idx + 16'd1;
                        if (pat_idx == n_lat - 16'd1)
                            state <= S_DONE;
                    end
                default:
                    state <= S_IDLE;
            endcase
        end

endmodule

// File: doc/lbist_prpg.md
LBIST_PRPG -- requirements
Module: lbist_prpg

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N, default 24: LFSR and pattern width; only 23 and 24 are legal, any other value SHALL be an elaboration error.
REQ-003 Parameter SEED, default 100: reset seed value.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port seed_load, input, 1 bit: load seed_in into the LFSR (accepted in IDLE only).
REQ-007 Port seed_in, input, N bits: runtime seed.
REQ-008 Port start, input, 1 bit: begin a pattern run (accepted in IDLE only).
REQ-009 Port abort, input, 1 bit: terminate the current run.
REQ-010 Port n_patterns, input, 16 bits: run length, sampled when start is accepted.
REQ-011 Port pattern, output, N bits: current pattern to the circuit under test.
REQ-012 Port pattern_valid, output, 1 bit: pattern holds a valid value.
REQ-013 Port pattern_ready, input, 1 bit: the consumer accepts the pattern.
REQ-014 Port misr_en, output, 1 bit: enable for the downstream signature register; equals pattern_valid AND pattern_ready.
REQ-015 Port busy, output, 1 bit: high in RUN.
REQ-016 Port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-017 Port pat_idx, output, 16 bits: index of the current pattern.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-019 IDLE -> RUN when start=1 and the latched n_patterns != 0.
REQ-020 IDLE -> DONE when start=1 and n_patterns = 0; no pattern is issued.
REQ-021 In RUN, pattern_valid SHALL be 1 and pattern SHALL be stable until the handshake completes.
REQ-022 A handshake (valid AND ready) SHALL step the LFSR once and increment pat_idx on the next edge.
REQ-023 A handshake when pat_idx = n_patterns-1 SHALL go to DONE; the LFSR still steps.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; pat_idx holds its final value until the next start.
REQ-025 Accepting start SHALL clear pat_idx to 0.
REQ-026 LFSR step (Galois, XOR): r'[0]=r[N-1]; r'[i]=r[i-1] XOR (tap[i] AND r[N-1]).
REQ-027 Taps for N=24 (x^24+x^7+x^2+x+1): bits 1, 2 and 7.
REQ-028 Taps for N=23 (x^23+x^5+1): bit 5.
REQ-029 Any seed, from SEED or from seed_in, that equals zero SHALL be replaced by 1, so the LFSR never locks up.
REQ-030 seed_load in IDLE SHALL load the seed on the next edge.
REQ-031 seed_load together with start SHALL load the seed first; the run then starts from the new seed.
REQ-032 seed_load and start outside IDLE SHALL be ignored.
REQ-033 abort in RUN SHALL go to IDLE on the next edge: valid low, no done pulse, LFSR holds its value.
REQ-034 abort has priority over a simultaneous handshake; the LFSR does not step.
REQ-035 The LFSR state SHALL persist across runs unless it is reseeded.

Reset
REQ-036 While rst=1 at a clock edge: state IDLE, LFSR = SEED (zero -> 1), pat_idx 0, pattern_valid 0, busy 0, done 0, misr_en 0.
REQ-037 rst SHALL override every other input, including mid-run.

Configuration
REQ-038 With LBIST_PRPG_PHASE_SHIFT_EN defined: pattern[i] = r[i] XOR r[(i+7) mod N] XOR r[(i+13) mod N].
REQ-039 Without LBIST_PRPG_PHASE_SHIFT_EN: pattern = r.

Structure
REQ-040 Package lbist_pkg SHALL hold the FSM state enum, the tap masks for N=23/24 and the phase-shift offsets 7 and 13.
REQ-041 The LFSR register, its step and its zero-seed substitution SHALL live in sub-module lbist_lfsr_core; lbist_prpg holds the FSM, counter and handshake.

Verification
REQ-042 N=24, macro off, seed_load seed_in=0x000001, start n_patterns=3, ready=1 -> patterns 0x000001, 0x000002, 0x000004; misr_en high for 3 cycles; done pulses once.
REQ-043 Seed 0x800000, one handshake -> next pattern 0x000087.
REQ-044 seed_in=0 loaded -> first pattern 0x000001.
REQ-045 ready held low for 5 cycles in RUN -> pattern stable, pat_idx unchanged, misr_en=0.
REQ-046 abort asserted with valid and ready both high at pat_idx=1 -> IDLE next cycle, no done, LFSR not stepped.
REQ-047 start with n_patterns=0 -> done pulse one cycle later; pattern_valid never asserted.
